// File: rtl/comparator_pipelined.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// comparator_pipelined
//
// Pipelined magnitude comparator used for age/tag ordering. Two WIDTH-bit
// operands are compared CHUNK bits per stage, most significant slice first.
// The first slice that differs decides the result, and the decision then
// rides down the pipe unchanged. A valid/ready handshake, an opaque tag and
// a global enable stall are carried alongside each operation.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   enable       1 = pipeline runs, 0 = everything frozen and outputs masked
//   in_valid     operands presented
//   in_ready     stage 0 can take an operation this cycle
//   in1, in2     operands
//   signed_mode  1 = two's-complement compare, 0 = unsigned
//   in_tag       tag travelling with the operation
//   out_valid    result available
//   out_ready    consumer accepts the result
//   in1_greater  in1 > in2
//   in2_greater  in2 > in1
//   equal        in1 == in2
//   out_tag      tag of the presented result
// -----------------------------------------------------------------------------
module comparator_pipelined #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             signed_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             in1_greater,
    output logic             in2_greater,
    output logic             equal,
    output logic [TAG_W-1:0] out_tag
);

    localparam int STAGES = WIDTH / CHUNK;

    // Decision carried down the pipe. Once decided, gt/lt never change.
    typedef struct packed {
        logic decided;
        logic gt;
        logic lt;
    } dec_t;

    // One compare step: an undecided state is resolved by the first slice
    // pair that differs; equal slices leave it undecided.
    function automatic dec_t step(input dec_t s,
                                  input logic [CHUNK-1:0] a,
                                  input logic [CHUNK-1:0] b);
        dec_t r;
        // NOTE: r gets a full default before any branch so every path assigns it.
        r = s;
        if (!s.decided) begin
            if (a > b) begin
                r = '{decided: 1'b1, gt: 1'b1, lt: 1'b0};
            end else if (a < b) begin
                r = '{decided: 1'b1, gt: 1'b0, lt: 1'b1};
            end
        end
        return r;
    endfunction

    // Stage registers.
    logic [STAGES-1:0] valid_q;
    dec_t              dec_q [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    // Operands are kept left-aligned: the slice still to be compared by the
    // next stage always sits in the top CHUNK bits.
    logic [WIDTH-1:0]  op1_q [STAGES];
    logic [WIDTH-1:0]  op2_q [STAGES];

    // Source of each stage (input port for stage 0, previous stage otherwise)
    // and the resulting next-state values.
    logic              src_valid [STAGES];
    dec_t              src_dec   [STAGES];
    logic [TAG_W-1:0]  src_tag   [STAGES];
    logic [WIDTH-1:0]  src_op1   [STAGES];
    logic [WIDTH-1:0]  src_op2   [STAGES];
    dec_t              dec_d     [STAGES];
    logic [WIDTH-1:0]  op1_d     [STAGES];
    logic [WIDTH-1:0]  op2_d     [STAGES];

    // load[k]: stage k takes whatever its source holds (entry or bubble).
    // A stage loads when it is empty or its content moves on, so bubbles
    // collapse and a full pipe drains with pass-through ready.
    logic [STAGES-1:0] load;

    assign load[STAGES-1] = !valid_q[STAGES-1] | out_ready;
    for (genvar k = 0; k < STAGES-1; k++) begin : g_load
        assign load[k] = !valid_q[k] | load[k+1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            // Flipping the sign bit of both operands maps two's-complement
            // order onto unsigned order, so only the top slice needs it and
            // signed_mode is consumed here at acceptance.
            assign src_valid[k] = in_valid;
            assign src_dec[k]   = '0;
            assign src_tag[k]   = in_tag;
            assign src_op1[k]   = {in1[WIDTH-1] ^ signed_mode, in1[WIDTH-2:0]};
            assign src_op2[k]   = {in2[WIDTH-1] ^ signed_mode, in2[WIDTH-2:0]};
        end else begin : g_body
            assign src_valid[k] = valid_q[k-1];
            assign src_dec[k]   = dec_q[k-1];
            assign src_tag[k]   = tag_q[k-1];
            assign src_op1[k]   = op1_q[k-1];
            assign src_op2[k]   = op2_q[k-1];
        end

        assign dec_d[k] = step(src_dec[k],
                               src_op1[k][WIDTH-1 -: CHUNK],
                               src_op2[k][WIDTH-1 -: CHUNK]);
        assign op1_d[k] = src_op1[k] << CHUNK;
        assign op2_d[k] = src_op2[k] << CHUNK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                dec_q[k] <= '0;
                tag_q[k] <= '0;
                op1_q[k] <= '0;
                op2_q[k] <= '0;
            end
        end else if (enable) begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    // NOTE: non-blocking so every stage sees its source's pre-edge value.
                    valid_q[k] <= src_valid[k];
                    // Payload only moves with a real entry; bubbles leave it alone.
                    if (src_valid[k]) begin
                        dec_q[k] <= dec_d[k];
                        tag_q[k] <= src_tag[k];
                        op1_q[k] <= op1_d[k];
                        op2_q[k] <= op2_d[k];
                    end
                end
            end
        end
    end

    // Outputs come straight from the last stage, masked by enable/valid.
    assign in_ready    = enable & load[0];
    assign out_valid   = enable & valid_q[STAGES-1];
    assign in1_greater = out_valid & dec_q[STAGES-1].gt;
    assign in2_greater = out_valid & dec_q[STAGES-1].lt;
    assign equal       = out_valid & !dec_q[STAGES-1].gt & !dec_q[STAGES-1].lt;
    assign out_tag     = out_valid ? tag_q[STAGES-1] : '0;

endmodule

// File: tb/tb_comparator_pipelined.sv
`timescale 1ns/1ps
module tb_comparator_pipelined;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             signed_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic             in1_greater;
    logic             in2_greater;
    logic             equal;
    logic [TAG_W-1:0] out_tag;

    comparator_pipelined #(.WIDTH(WIDTH), .CHUNK(CHUNK), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in1         (in1),
        .in2         (in2),
        .signed_mode (signed_mode),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .in1_greater (in1_greater),
        .in2_greater (in2_greater),
        .equal       (equal),
        .out_tag     (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             gt;
        logic             lt;
        logic             eq;
        logic [TAG_W-1:0] tag;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic sm, input logic [TAG_W-1:0] tag);
        res_t r;
        r.gt  = sm ? ($signed(a) > $signed(b)) : (a > b);
        r.lt  = sm ? ($signed(a) < $signed(b)) : (a < b);
        r.eq  = (a == b);
        r.tag = tag;
        return r;
    endfunction

    function automatic res_t hand(input logic [1:0] code, input logic [TAG_W-1:0] tag);
        res_t r;
        r.gt  = (code == 2'd1);
        r.lt  = (code == 2'd2);
        r.eq  = (code == 2'd0);
        r.tag = tag;
        return r;
    endfunction

    // Monitor: every output transfer pops and compares one expected result.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                check("onehot", $countones({in1_greater, in2_greater, equal}), 1);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got tag 0x%0h with no result expected", out_tag);
                    end else begin
                        res_t e;
                        e = exp_q.pop_front();
                        check("result", {in1_greater, in2_greater, equal, out_tag}, e);
                    end
                end
            end
        end
    end

    // Presents one operation and waits (bounded) for it to be accepted.
    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sm,
                        input logic [TAG_W-1:0] tag, input res_t e);
        bit ok;
        ok          = 1'b0;
        in_valid    = 1'b1;
        in1         = a;
        in2         = b;
        signed_mode = sm;
        in_tag      = tag;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
        end
        check("accept", ok, 1);
        if (ok) exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(posedge clk);
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Sends into an empty pipe and checks out_valid appears after edge t+3.
    task automatic check_latency(input logic [31:0] a, input logic [31:0] b, input logic sm,
                                 input logic [TAG_W-1:0] tag, input res_t e);
        send(a, b, sm, tag, e);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("latency_early", out_valid, 0);
            @(posedge clk);
        end
        @(negedge clk);
        check("latency_due", out_valid, 1);
        @(posedge clk);
        #1;
    endtask

    // Directed vectors: a, b, signed, expected (0 eq, 1 in1 greater, 2 in2 greater).
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sm;
        logic [1:0]  code;
    } vec_t;

    vec_t vecs[10] = '{
        '{32'h12345678, 32'h12345677, 1'b0, 2'd1},
        '{32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2'd0},
        '{32'h00000001, 32'h80000000, 1'b0, 2'd2},
        '{32'hFFFFFFFF, 32'h00000001, 1'b1, 2'd2},
        '{32'hFFFFFFFF, 32'h00000001, 1'b0, 2'd1},
        '{32'h80000000, 32'h7FFFFFFF, 1'b1, 2'd2},
        '{32'h80000000, 32'h7FFFFFFF, 1'b0, 2'd1},
        '{32'h00000000, 32'h00000000, 1'b1, 2'd0},
        '{32'h12345600, 32'h12345700, 1'b0, 2'd2},
        '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 2'd1}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t first_e;
        rst_n       = 1'b0;
        enable      = 1'b1;
        out_ready   = 1'b1;
        in_valid    = 1'b0;
        in1         = '0;
        in2         = '0;
        signed_mode = 1'b0;
        in_tag      = '0;

        // Reset state.
        #1;
        check("reset_outputs", {out_valid, in1_greater, in2_greater, equal, out_tag}, 0);
        check("reset_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed compares; first one also measures latency.
        check_latency(vecs[0].a, vecs[0].b, vecs[0].sm, 4'd0, hand(vecs[0].code, 4'd0));
        for (int i = 1; i < 10; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].sm, TAG_W'(i), hand(vecs[i].code, TAG_W'(i)));
        end
        drain();

        // Back-to-back streaming: 16 ops, tags 0..15, results on 16 consecutive cycles.
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    logic [31:0] a, b;
                    a = $urandom;
                    b = $urandom;
                    if (i % 5 == 0) b = a;
                    else if (i % 3 == 0) b = a ^ 32'h1;
                    send(a, b, i[0], TAG_W'(i), model(a, b, i[0], TAG_W'(i)));
                end
            end
            begin
                int  run;
                bit  seen;
                run  = 0;
                seen = 1'b0;
                for (int c = 0; c < 60; c++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        run++;
                        seen = 1'b1;
                    end else if (seen) begin
                        break;
                    end
                end
                check("stream_consecutive", run, 16);
            end
        join
        drain();

        // Backpressure: fill with out_ready low.
        out_ready = 1'b0;
        first_e   = model(32'h0000_0005, 32'h0000_0009, 1'b0, 4'hA);
        send(32'h0000_0005, 32'h0000_0009, 1'b0, 4'hA, first_e);
        send(32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 4'hB, model(32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 4'hB));
        send(32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 4'hC, model(32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 4'hC));
        send(32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 4'hD, model(32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 4'hD));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_in_ready", in_ready, 0);
            check("full_hold", {out_valid, in1_greater, in2_greater, equal, out_tag}, {1'b1, first_e});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("passthrough_ready", in_ready, 1);
        @(posedge clk);
        #1;
        drain();

        // Random out_ready toggling while streaming.
        fork
            begin
                repeat (80) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    logic [31:0] a, b;
                    a = $urandom;
                    b = (i % 4 == 0) ? a : $urandom;
                    send(a, b, i[1], TAG_W'(i), model(a, b, i[1], TAG_W'(i)));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Enable stall mid-stream.
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    logic [31:0] a, b;
                    a = $urandom;
                    b = (i % 3 == 0) ? a : $urandom;
                    send(a, b, i[0], TAG_W'(i + 3), model(a, b, i[0], TAG_W'(i + 3)));
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1 enable = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_masked", {out_valid, in_ready, in1_greater, in2_greater, equal}, 0);
                    @(posedge clk);
                end
                #1 enable = 1'b1;
            end
        join
        drain();

        // Asynchronous reset with three operations in flight.
        send(32'h0000_0010, 32'h0000_0001, 1'b0, 4'h1, model(32'h0000_0010, 32'h0000_0001, 1'b0, 4'h1));
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 4'h2, model(32'h8000_0000, 32'h0000_0001, 1'b1, 4'h2));
        send(32'h5555_5555, 32'h5555_5555, 1'b0, 4'h3, model(32'h5555_5555, 32'h5555_5555, 1'b0, 4'h3));
        #2 rst_n = 1'b0;
        #1;
        check("midreset_outputs", {out_valid, in1_greater, in2_greater, equal, out_tag}, 0);
        check("midreset_in_ready", in_ready, 1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;
        check_latency(32'h0000_0002, 32'h0000_0003, 1'b0, 4'h7, hand(2'd2, 4'h7));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
